// File: rtl/win_loader_mg_pkg.sv
// Shared types and window geometry for the successor window loader.
package pkg_win_loader_mg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_BLOCKING   = 4;
  localparam int unsigned DEF_NUM_GROUPS = 4;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_Y_W        = 9;
  localparam int unsigned DEF_BLK_W      = 7;
  localparam int unsigned DEF_WIN_W      = 7;
  localparam int unsigned DEF_MIN_WIN    = 20;
  localparam int unsigned DEF_MAX_WIN    = 120;
  localparam int unsigned DEF_RD_LATENCY = 2;

  typedef struct packed {
    logic [31:0] wbw;
    logic [31:0] rb;
    logic [31:0] rows;
  } win_geom_t;

  // wbw: window blocks per row incl. alignment margin; rb: blocks read per row
  function automatic win_geom_t calc_geom(input logic [31:0] win,
                                          input logic [31:0] blocking,
                                          input logic [31:0] groups);
    win_geom_t g;
    g.wbw  = (win + blocking - 32'd1) / blocking + 32'd1;
    g.rb   = g.wbw + groups - 32'd1;
    g.rows = win + 32'd1;
    return g;
  endfunction

endpackage

// File: rtl/win_loader_mg_rdpipe.sv
// Read-latency tag pipeline and per-group write-enable/address decode.
module win_loader_mg_rdpipe
  import pkg_win_loader_mg::*;
#(
  parameter int unsigned NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned BLK_W      = DEF_BLK_W,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [Y_W-1:0]              in_r,
  input  logic [BLK_W-1:0]            in_b,
  input  logic [BLK_W:0]              wbw,
  output logic [NUM_GROUPS-1:0]       we,
  output logic [NUM_GROUPS*Y_W-1:0]   waddr_y,
  output logic [NUM_GROUPS*BLK_W-1:0] waddr_block
);

  logic             vld_q [RD_LATENCY];
  logic [Y_W-1:0]   r_q   [RD_LATENCY];
  logic [BLK_W-1:0] b_q   [RD_LATENCY];
  logic signed [BLK_W:0] diff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        r_q[i]   <= '0;
        b_q[i]   <= '0;
      end
    end else begin
      vld_q[0] <= in_valid & ~flush;
      r_q[0]   <= in_r;
      b_q[0]   <= in_b;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush;
        r_q[i]   <= r_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
    end
  end

  // group g owns read block b when 0 <= b-g < wbw; idle addresses stay 0
  always_comb begin
    we          = '0;
    waddr_y     = '0;
    waddr_block = '0;
    diff        = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      diff = $signed({1'b0, b_q[RD_LATENCY-1]}) - $signed((BLK_W+1)'(g));
      if (vld_q[RD_LATENCY-1] && !flush && !diff[BLK_W] &&
          ({1'b0, diff[BLK_W-1:0]} < wbw)) begin
        we[g]                       = 1'b1;
        waddr_y[g*Y_W +: Y_W]       = r_q[RD_LATENCY-1];
        waddr_block[g*BLK_W +: BLK_W] = diff[BLK_W-1:0];
      end
    end
  end

endmodule

// File: rtl/win_loader_mg.sv
// Successor window loader: streams one window plus margin from the integral
// cache into the window caches of all core groups.
module win_loader_mg
  import pkg_win_loader_mg::*;
#(
  parameter int unsigned BLOCKING   = DEF_BLOCKING,
  parameter int unsigned NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned BLK_W      = DEF_BLK_W,
  parameter int unsigned WIN_W      = DEF_WIN_W,
  parameter int unsigned MIN_WIN    = DEF_MIN_WIN,
  parameter int unsigned MAX_WIN    = DEF_MAX_WIN,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         ack,
  input  logic [Y_W-1:0]               start_y,
  input  logic [BLK_W-1:0]             start_block,
  input  logic [WIN_W-1:0]             win_size,
  input  logic                         dbl_buf,
  output logic                         ready,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [Y_W-1:0]               rd_addr_y,
  output logic [BLK_W-1:0]             rd_addr_block,
  input  logic                         rd_stall,
  input  logic [BLOCKING*DATA_W-1:0]   rd_data,
  output logic [NUM_GROUPS-1:0]        wc_we,
  output logic [NUM_GROUPS*Y_W-1:0]    wc_waddr_y,
  output logic [NUM_GROUPS*BLK_W-1:0]  wc_waddr_block,
  output logic [BLOCKING*DATA_W-1:0]   wc_wdata,
  output logic                         wc_dbl_buf
);

  state_t state_q, state_d;

  logic [Y_W-1:0]   sy_q, r_q, rows_m1_q;
  logic [BLK_W-1:0] sblk_q, b_q, rb_m1_q;
  logic [BLK_W:0]   wbw_q;
  logic [WIN_W-1:0] win_q;
  logic [2:0]       drain_q;
  logic             err_q, dbl_q;

  win_geom_t geom;
  logic      bad_win, fire, last_rd, kill, set_err;

  always_comb begin
    geom    = calc_geom(32'(win_q), BLOCKING, NUM_GROUPS);
    bad_win = (32'(win_q) < MIN_WIN) || (32'(win_q) > MAX_WIN) ||
              ((32'(sblk_q) + geom.rb) > (32'd1 << BLK_W)) ||
              ((32'(sy_q) + geom.rows) > (32'd1 << Y_W));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    kill    = 1'b0;
    set_err = 1'b0;
    last_rd = (r_q == rows_m1_q) && (b_q == rb_m1_q);
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CHECK;
      ST_CHECK: begin
        if (abort || bad_win) begin
          kill    = abort;
          set_err = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          kill    = 1'b1;
          set_err = 1'b1;
          state_d = ST_DONE;
        end else if (!rd_stall) begin
          fire = 1'b1;
          if (last_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          kill    = 1'b1;
          set_err = 1'b1;
          state_d = ST_DONE;
        end else if (drain_q == 3'(RD_LATENCY - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sy_q      <= '0;
      sblk_q    <= '0;
      win_q     <= '0;
      dbl_q     <= 1'b0;
      r_q       <= '0;
      b_q       <= '0;
      wbw_q     <= '0;
      rb_m1_q   <= '0;
      rows_m1_q <= '0;
      drain_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        sy_q   <= start_y;
        sblk_q <= start_block;
        win_q  <= win_size;
        dbl_q  <= dbl_buf;
        r_q    <= '0;
        b_q    <= '0;
      end
      if (state_q == ST_CHECK) begin
        wbw_q     <= (BLK_W+1)'(geom.wbw);
        rb_m1_q   <= BLK_W'(geom.rb - 32'd1);
        rows_m1_q <= Y_W'(geom.rows - 32'd1);
      end
      if (fire) begin
        if (b_q == rb_m1_q) begin
          b_q <= '0;
          r_q <= r_q + Y_W'(1);
        end else begin
          b_q <= b_q + BLK_W'(1);
        end
      end
      drain_q <= (state_q == ST_DRAIN) ? drain_q + 3'd1 : '0;
      if (set_err)                       err_q <= 1'b1;
      else if (state_q == ST_DONE && ack) err_q <= 1'b0;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
  assign rd_en         = fire;
  assign rd_addr_y     = sy_q + r_q;
  assign rd_addr_block = sblk_q + b_q;
  assign wc_wdata      = rd_data;
  assign wc_dbl_buf    = dbl_q;

  win_loader_mg_rdpipe #(
    .NUM_GROUPS (NUM_GROUPS),
    .Y_W        (Y_W),
    .BLK_W      (BLK_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rdpipe (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (kill),
    .in_valid    (fire),
    .in_r        (r_q),
    .in_b        (b_q),
    .wbw         (wbw_q),
    .we          (wc_we),
    .waddr_y     (wc_waddr_y),
    .waddr_block (wc_waddr_block)
  );

endmodule

// File: tb/tb_win_loader_mg.sv
// Bench for win_loader_mg: integral cache model plus window-level scoreboard.
module tb_win_loader_mg;

  localparam int unsigned B   = 4;
  localparam int unsigned NG  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned YW  = 9;
  localparam int unsigned BW  = 7;
  localparam int unsigned WW  = 7;
  localparam int unsigned LAT = 4;
  localparam int unsigned BDW = B * DW;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, ack = 1'b0;
  logic dbl_buf = 1'b0, rd_stall = 1'b0;
  logic [YW-1:0] start_y = '0;
  logic [BW-1:0] start_block = '0;
  logic [WW-1:0] win_size = '0;
  logic ready, done, err, rd_en, wc_dbl_buf;
  logic [YW-1:0] rd_addr_y;
  logic [BW-1:0] rd_addr_block;
  logic [BDW-1:0] rd_data, wc_wdata;
  logic [NG-1:0] wc_we;
  logic [NG*YW-1:0] wc_waddr_y;
  logic [NG*BW-1:0] wc_waddr_block;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  win_loader_mg #(
    .BLOCKING(B), .NUM_GROUPS(NG), .DATA_W(DW), .Y_W(YW), .BLK_W(BW),
    .WIN_W(WW), .MIN_WIN(20), .MAX_WIN(120), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .ack(ack),
    .start_y(start_y), .start_block(start_block), .win_size(win_size),
    .dbl_buf(dbl_buf), .ready(ready), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_y(rd_addr_y), .rd_addr_block(rd_addr_block),
    .rd_stall(rd_stall), .rd_data(rd_data), .wc_we(wc_we),
    .wc_waddr_y(wc_waddr_y), .wc_waddr_block(wc_waddr_block),
    .wc_wdata(wc_wdata), .wc_dbl_buf(wc_dbl_buf)
  );

  function automatic logic [BDW-1:0] pix(input logic [YW-1:0] y, input logic [BW-1:0] b);
    logic [BDW-1:0] v;
    for (int unsigned i = 0; i < B; i++) v[i*DW +: DW] = {y, b, 16'(i)} ^ 32'hA5C3_0F1E;
    return v;
  endfunction

  // integral cache: data for the address read LAT cycles earlier
  logic cv [LAT] = '{default: 1'b0};
  logic [YW+BW-1:0] ca [LAT];
  always @(posedge clk) begin
    cv[0] <= rd_en;
    ca[0] <= {rd_addr_y, rd_addr_block};
    for (int unsigned i = 1; i < LAT; i++) begin
      cv[i] <= cv[i-1];
      ca[i] <= ca[i-1];
    end
  end
  always_comb rd_data = cv[LAT-1] ? pix(ca[LAT-1][YW+BW-1:BW], ca[LAT-1][BW-1:0])
                                  : {B{32'hDEAD_BEEF}};

  logic [YW+BW-1:0]     rq  [$];
  logic [YW+BW+BDW-1:0] wq0 [$];
  logic [YW+BW+BDW-1:0] wq1 [$];
  int unsigned m_issued, m_nreads, m_stalls, tick_idx, rd_cnt, wr_cnt0, wr_cnt1;
  int unsigned stall_mode = 0;
  bit noise_start = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned wbw_of(input int unsigned win);
    return (win + B - 1) / B + 1;
  endfunction

  function automatic bit accepted(input int unsigned win, input int unsigned sy, input int unsigned sb);
    return win >= 20 && win <= 120 && sb + wbw_of(win) + NG - 1 <= 128 && sy + win + 1 <= 512;
  endfunction

  task automatic clear_model();
    rq.delete(); wq0.delete(); wq1.delete();
    m_nreads = 0; m_issued = 0; m_stalls = 0;
    rd_cnt = 0; wr_cnt0 = 0; wr_cnt1 = 0;
  endtask

  task automatic build_model(input int unsigned win, input int unsigned sy, input int unsigned sb);
    int unsigned wbw, rb;
    clear_model();
    wbw = wbw_of(win);
    rb  = wbw + NG - 1;
    for (int unsigned r = 0; r <= win; r++) begin
      for (int unsigned b = 0; b < rb; b++) begin
        logic [YW-1:0] ay;
        logic [BW-1:0] ab;
        ay = YW'(sy + r);
        ab = BW'(sb + b);
        rq.push_back({ay, ab});
        if (b < wbw) wq0.push_back({YW'(r), BW'(b), pix(ay, ab)});
        if (b >= 1 && b - 1 < wbw) wq1.push_back({YW'(r), BW'(b - 1), pix(ay, ab)});
      end
    end
    m_nreads = rq.size();
  endtask

  task automatic monitor();
    logic [YW+BW+BDW-1:0] obs;
    if (rd_stall) chk("rd_while_stall", rd_en, 0);
    if (rd_en) begin
      rd_cnt++;
      if (rq.size() == 0) chk("rd_extra", rd_en, 0);
      else chk("rd_addr", {rd_addr_y, rd_addr_block}, rq.pop_front());
    end
    if (wc_we[0]) begin
      wr_cnt0++;
      obs = {wc_waddr_y[0 +: YW], wc_waddr_block[0 +: BW], wc_wdata};
      if (wq0.size() == 0) chk("wr_extra_g0", wc_we[0], 0);
      else chk("wr_g0", obs, wq0.pop_front());
    end
    if (wc_we[1]) begin
      wr_cnt1++;
      obs = {wc_waddr_y[YW +: YW], wc_waddr_block[BW +: BW], wc_wdata};
      if (wq1.size() == 0) chk("wr_extra_g1", wc_we[1], 0);
      else chk("wr_g1", obs, wq1.pop_front());
    end
  endtask

  task automatic tick();
    if (stall_mode == 1)      rd_stall = (tick_idx % 3 == 2);
    else if (stall_mode == 2) rd_stall = ($urandom_range(0, 3) == 0);
    else                      rd_stall = 1'b0;
    if (noise_start) start = 1'($urandom_range(0, 1));
    if (tick_idx >= 2 && m_issued < m_nreads) begin
      if (rd_stall) m_stalls++;
      else          m_issued++;
    end
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
    tick_idx++;
  endtask

  task automatic launch(input int unsigned win, input int unsigned sy, input int unsigned sb,
                        input logic dbl);
    if (accepted(win, sy, sb)) build_model(win, sy, sb);
    else clear_model();
    tick_idx = 0;
    win_size = WW'(win); start_y = YW'(sy); start_block = BW'(sb); dbl_buf = dbl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_load(input int unsigned win, input int unsigned sy, input int unsigned sb,
                          input int unsigned smode, input bit noise);
    int unsigned lat;
    bit ok;
    logic dbl;
    ok  = accepted(win, sy, sb);
    dbl = 1'($urandom_range(0, 1));
    stall_mode = smode;
    launch(win, sy, sb, dbl);
    noise_start = noise;
    lat = 1;
    while (!done && lat < 20000) begin
      tick();
      lat++;
    end
    noise_start = 1'b0; start = 1'b0; stall_mode = 0;
    chk("done", done, 1);
    chk("err", err, !ok);
    chk("latency", lat, ok ? 2 + m_nreads + m_stalls + LAT : 2);
    chk("wc_dbl_buf", wc_dbl_buf, dbl);
    chk("reads_left", rq.size(), 0);
    chk("wr0_left", wq0.size(), 0);
    chk("wr1_left", wq1.size(), 0);
    chk("rd_count", rd_cnt, ok ? (win + 1) * (wbw_of(win) + NG - 1) : 0);
    chk("wr0_count", wr_cnt0, ok ? (win + 1) * wbw_of(win) : 0);
    chk("wr1_count", wr_cnt1, ok ? (win + 1) * wbw_of(win) : 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ready_after_ack", ready, 1);
    chk("err_cleared", err, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, {rd_addr_y, rd_addr_block}, 0);
    chk({tag, "_wc_we"}, wc_we, 0);
    chk({tag, "_wc_waddr"}, {wc_waddr_y, wc_waddr_block}, 0);
    chk({tag, "_wc_dbl_buf"}, wc_dbl_buf, 0);
  endtask

  initial begin
    int unsigned guard;
    clear_model();
    tick_idx = 0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // nominal window, then the same with a stall every third cycle
    run_load(24, 10, 3, 0, 0);
    chk("nominal_rd_count", rd_cnt, 200);
    chk("nominal_wr0_count", wr_cnt0, 175);
    run_load(24, 10, 3, 1, 0);

    // acceptance boundaries
    run_load(19, 10, 3, 0, 0);
    run_load(121, 0, 0, 0, 0);
    run_load(24, 10, 126, 0, 0);
    run_load(24, 10, 120, 0, 0);
    run_load(20, 0, 0, 0, 0);
    run_load(120, 391, 0, 0, 0);
    run_load(120, 392, 0, 0, 0);

    // abort on read #50
    stall_mode = 0;
    launch(24, 10, 3, 1'b1);
    guard = 0;
    while (m_issued < 49 && guard < 1000) begin
      tick();
      guard++;
    end
    chk("abort_reach", m_issued, 49);
    abort = 1'b1;
    #1;
    chk("abort_rd_en", rd_en, 0);
    chk("abort_wc_we", wc_we, 0);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_done", done, 1);
    chk("abort_err", err, 1);
    chk("abort_wc_we_next", wc_we, 0);
    clear_model();
    @(negedge clk);
    repeat (LAT + 2) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("abort_ready", ready, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_ignored", {ready, err}, 2'b10);

    // reset in the middle of streaming
    launch(30, 5, 7, 1'b1);
    repeat (40) tick();
    resetn = 1'b0;
    #1;
    check_quiet("midreset");
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_model();
    repeat (LAT + 2) tick();
    chk("midreset_ready", ready, 1);
    run_load(30, 5, 7, 0, 0);

    // random legal windows with random stalls and start noise
    for (int unsigned k = 0; k < 4; k++) begin
      int unsigned w, sb, sy;
      w  = $urandom_range(20, 120);
      sb = $urandom_range(0, 128 - (wbw_of(w) + NG - 1));
      sy = $urandom_range(0, 512 - (w + 1));
      run_load(w, sy, sb, 2, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/win_loader_mg.md
Name: win_loader_mg

Overview:
- Parametrised successor window loader: streams one candidate window (plus alignment margin) from the integral image cache into the window caches of NUM_GROUPS core groups. Each group holds BLOCKING cores offset by one pixel.
- Sits between the scan controller (start/done/ack) and the per-core window caches. Per-core pixel alignment happens downstream in the existing per-core alignment units.
- New versus the previous generation:
  - runtime-checked window size with an error exit
  - parametrised read latency
  - read-stall backpressure
  - abort
  - per-group write enables derived directly from block offset, with no fixed delay chain

Parameters:
- BLOCKING, 4, pixels per integral-cache block word
- NUM_GROUPS, 4, core groups; group g is offset g blocks from group 0
- DATA_W, 32, bits per integral pixel; block word is BLOCKING*DATA_W
- Y_W, 9, integral row address width
- BLK_W, 7, integral block address width
- WIN_W, 7, win_size width
- MIN_WIN, 20, smallest legal window size
- MAX_WIN, 120, largest legal window size
- RD_LATENCY, 2, cycles from rd_en to valid rd_data, range 1..4

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request, sampled only in IDLE
- abort  in  1  stop the current load
- ack  in  1  acknowledges done
- start_y  in  Y_W  first integral row
- start_block  in  BLK_W  first integral block
- win_size  in  WIN_W  window edge in pixels
- dbl_buf  in  1  target half of the double-buffered caches
- ready  out  1  high in IDLE
- done  out  1  high in DONE
- err  out  1  valid while done; 1 = rejected or aborted
- rd_en  out  1  integral cache read strobe
- rd_addr_y  out  Y_W  read row
- rd_addr_block  out  BLK_W  read block
- rd_stall  in  1  cache busy; a read is not issued while high
- rd_data  in  BLOCKING*DATA_W  read data, RD_LATENCY after rd_en
- wc_we  out  NUM_GROUPS  per-group write enable
- wc_waddr_y  out  NUM_GROUPS*Y_W  per-group window row
- wc_waddr_block  out  NUM_GROUPS*BLK_W  per-group window block
- wc_wdata  out  BLOCKING*DATA_W  rd_data forwarded, shared by all groups
- wc_dbl_buf  out  1  latched dbl_buf

Behaviour:
- Reset: async, all registers 0 and state IDLE. Thus ready=1 and done, err, rd_en, wc_we, addresses, wc_dbl_buf are all 0.
- Derived values, latched in CHECK:
  - WBW = ceil(win_size/BLOCKING) + 1, window blocks per row
  - RB = WBW + NUM_GROUPS - 1, blocks read per row
  - ROWS = win_size + 1
- States:
  - IDLE: start -> CHECK. Latch inputs and wc_dbl_buf.
  - CHECK (1 cycle):
    - If win_size < MIN_WIN, win_size > MAX_WIN, start_block + RB > 2^BLK_W, or start_y + ROWS > 2^Y_W: set err=1 and go to DONE. No reads are issued.
    - Otherwise go to STREAM.
  - STREAM:
    - Each cycle with rd_stall=0, issue a read at (row r, block b) with addresses start_y+r and start_block+b.
    - b counts 0..RB-1, then wraps to 0 and r increments.
    - After the read with r=ROWS-1 and b=RB-1, go to DRAIN.
    - rd_stall=1 holds rd_en=0 and freezes the counters.
  - DRAIN: wait until the in-flight pipeline is empty, RD_LATENCY cycles, then go to DONE.
  - DONE: done=1; ack -> IDLE and err clears.
- Write path:
  - A RD_LATENCY-deep shift register carries {valid, r, b} and does not stall.
  - At its output, group g sets wc_we[g]=1 iff 0 <= b-g < WBW.
  - Group g addresses are waddr_y = r and waddr_block = b-g.
  - wc_wdata = rd_data, combinational passthrough.
- Abort, in CHECK, STREAM or DRAIN:
  - The next cycle enters DONE with err=1.
  - rd_en and wc_we are forced 0 from the abort cycle on, so in-flight data is discarded.
  - Abort in IDLE or DONE is ignored.
- Priority: abort over stall over normal operation. start outside IDLE is ignored.
- Reset mid-operation returns immediately to IDLE with all outputs 0. No partial write completes after resetn falls.
- Write count for an accepted window is exactly ROWS*WBW per group. Each (row, window block) pair is written once per group.
- Arithmetic: address sums are BLK_W/Y_W wide and cannot overflow because the CHECK bounds exclude it. b-g is compared signed, one bit wider.

Decomposition:
- pkg_win_loader_mg holds:
  - the state enum (IDLE, CHECK, STREAM, DRAIN, DONE)
  - default parameter constants
  - a function computing WBW/RB from win_size
- Sub-module win_loader_mg_rdpipe: the RD_LATENCY valid/tag shift register plus group-enable decode, one instance.

Test Plan:
- Nominal: BLOCKING=4, NUM_GROUPS=2, win_size=24, start_y=10, start_block=3. Expect:
  - RB=8, WBW=7, 200 reads; rd_addr_y 10..34, rd_addr_block 3..10
  - group0 we on b=0..6, group1 on b=1..7
  - 175 writes per group, then done, err=0
- Stall: same setup with rd_stall high every third cycle -> identical write set and order, completion delayed by the number of stall cycles, no duplicate reads.
- Reject: win_size=19 -> CHECK to DONE in 2 cycles, err=1, zero rd_en; start_block=126 with RB=8 -> err=1.
- Abort: assert abort at read #50 -> wc_we=0 from that cycle, done=1 next cycle with err=1; ack returns ready=1.
- Latency sweep RD_LATENCY=1 and 4 -> each write coincides with the rd_data of its tagged read, checked by a scoreboard against a cache model.
- Reset mid-STREAM: resetn low for 1 cycle -> all outputs 0 immediately, ready=1 after release; a new start completes normally.
